jglim_seven_seg: RTL and testbench



---
 rtl/jglim_seven_seg.sv | 95 +++++++++
 tb/tb_jglim_seven_seg.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/jglim_seven_seg.sv
// Single-digit seven-segment counter for an 8-in/8-out user slot.
// A prescaler divides the slot clock, and the digit steps once per prescaler period.
module jglim_seven_seg #(
  parameter int unsigned MAX_COUNT = 1000
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned PRESC_W = 24;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(MAX_COUNT - 1);
  localparam logic [DIGIT_W-1:0] HEX_LAST   = DIGIT_W'(15);
  localparam logic [DIGIT_W-1:0] BCD_LAST   = DIGIT_W'(9);

  logic clk;
  logic rst;
  logic bcd_mode;
  logic pause;
  logic unused_in;

  assign clk       = io_in[0];
  assign rst       = io_in[1];
  assign bcd_mode  = io_in[2];
  assign pause     = io_in[3];
  assign unused_in = ^io_in[7:4];

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [DIGIT_W-1:0] digit_next;
  logic [SEG_W-1:0]   seg_c;
  logic               max_c;

  // Next digit value. An out-of-range digit left from hex mode folds back to 0 in BCD mode.
  always_comb begin
    digit_next = digit_q + DIGIT_W'(1);
    if (bcd_mode && (digit_q >= BCD_LAST)) begin
      digit_next = '0;
    end
  end

  always_comb begin
    presc_d = presc_q;
    digit_d = digit_q;
    if (!pause) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        digit_d = digit_next;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  // Reset has priority over pause and mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      digit_q <= '0;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
    end
  end

  // Segment pattern {g,f,e,d,c,b,a}, active-high.
  always_comb begin
    seg_c = 7'h00;
    unique case (digit_q)
      4'h0: seg_c = 7'h3F;
      4'h1: seg_c = 7'h06;
      4'h2: seg_c = 7'h5B;
      4'h3: seg_c = 7'h4F;
      4'h4: seg_c = 7'h66;
      4'h5: seg_c = 7'h6D;
      4'h6: seg_c = 7'h7D;
      4'h7: seg_c = 7'h07;
      4'h8: seg_c = 7'h7F;
      4'h9: seg_c = 7'h6F;
      4'hA: seg_c = 7'h77;
      4'hB: seg_c = 7'h7C;
      4'hC: seg_c = 7'h39;
      4'hD: seg_c = 7'h5E;
      4'hE: seg_c = 7'h79;
      4'hF: seg_c = 7'h71;
      default: seg_c = 7'h00;
    endcase
  end

  assign max_c  = bcd_mode ? (digit_q == BCD_LAST) : (digit_q == HEX_LAST);
  assign io_out = {max_c, seg_c};

endmodule

// File: tb/tb_jglim_seven_seg.sv
// Directed bench for jglim_seven_seg with MAX_COUNT=10.
// It uses a vector table for the counting sequences and hand-written sequences for pause, reset and mode change.
module tb_jglim_seven_seg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bcd = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;
  int         checks = 0;
  int         failures = 0;

  assign io_in = {4'b1010, pause, bcd, rst, clk};

  jglim_seven_seg #(.MAX_COUNT(10)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       bcd;
    logic       pause;
    int         n;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] exp);
    checks++;
    if (io_out !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, io_out, exp);
    end
  endtask

  task automatic add(input logic r, input logic b, input logic p, input int n,
                     input logic [7:0] e);
    vec_t v;
    v.rst = r; v.bcd = b; v.pause = p; v.n = n; v.exp = e;
    vt.push_back(v);
  endtask

  initial begin
    // Reset, then the first two steps.
    add(1, 0, 0, 2,  8'h3F);
    add(0, 0, 0, 9,  8'h3F);
    add(0, 0, 0, 1,  8'h06);
    add(0, 0, 0, 10, 8'h5B);
    // Remainder of the hex cycle; the flag is set only at F.
    add(0, 0, 0, 10, 8'h4F);
    add(0, 0, 0, 10, 8'h66);
    add(0, 0, 0, 10, 8'h6D);
    add(0, 0, 0, 10, 8'h7D);
    add(0, 0, 0, 10, 8'h07);
    add(0, 0, 0, 10, 8'h7F);
    add(0, 0, 0, 10, 8'h6F);
    add(0, 0, 0, 10, 8'h77);
    add(0, 0, 0, 10, 8'h7C);
    add(0, 0, 0, 10, 8'h39);
    add(0, 0, 0, 10, 8'h5E);
    add(0, 0, 0, 10, 8'h79);
    add(0, 0, 0, 10, 8'hF1);
    add(0, 0, 0, 5,  8'hF1);
    add(0, 0, 0, 5,  8'h3F);
    // BCD cycle from 0; the flag is set only at 9.
    add(0, 1, 0, 10, 8'h06);
    add(0, 1, 0, 10, 8'h5B);
    add(0, 1, 0, 10, 8'h4F);
    add(0, 1, 0, 10, 8'h66);
    add(0, 1, 0, 10, 8'h6D);
    add(0, 1, 0, 10, 8'h7D);
    add(0, 1, 0, 10, 8'h07);
    add(0, 1, 0, 10, 8'h7F);
    add(0, 1, 0, 10, 8'hEF);
    add(0, 1, 0, 10, 8'h3F);
    add(0, 1, 0, 10, 8'h06);
    // Pause holds the digit; reset overrides pause.
    add(0, 1, 1, 30, 8'h06);
    add(1, 1, 1, 1,  8'h3F);

    foreach (vt[i]) begin
      rst = vt[i].rst; bcd = vt[i].bcd; pause = vt[i].pause;
      step(vt[i].n);
      chk($sformatf("vec%0d", i), vt[i].exp);
    end

    // Pause at digit 3 with the prescaler at 4. After release, the prescaler runs 4->9 and then steps.
    rst = 1'b1; bcd = 1'b0; pause = 1'b0;
    step(1);
    rst = 1'b0;
    step(34);
    chk("pause_pre", 8'h4F);
    pause = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk($sformatf("pause_hold%0d", i), 8'h4F);
    end
    pause = 1'b0;
    step(5);
    chk("pause_rel5", 8'h4F);
    step(1);
    chk("pause_step", 8'h66);

    // Mid-count reset at digit 7 with the prescaler at 6.
    step(36);
    chk("midrst_pre", 8'h07);
    rst = 1'b1;
    step(1);
    chk("midrst_clr", 8'h3F);
    rst = 1'b0;
    step(9);
    chk("midrst_hold", 8'h3F);
    step(1);
    chk("midrst_step", 8'h06);

    // Switch from hex to BCD at C: the flag stays 0, and the next step goes to 0.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(123);
    chk("sw_c_hex", 8'h39);
    bcd = 1'b1;
    #1;
    chk("sw_c_bcd", 8'h39);
    step(6);
    chk("sw_c_hold", 8'h39);
    step(1);
    chk("sw_c_step", 8'h3F);

    // The flag follows bcd_mode combinationally while the digit is F.
    bcd = 1'b0; rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(150);
    chk("flag_f_hex", 8'hF1);
    bcd = 1'b1;
    #1;
    chk("flag_f_bcd", 8'h71);
    bcd = 1'b0;
    #1;
    chk("flag_f_back", 8'hF1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
